// File: rtl/sw_debounce.sv
// sw_debounce: input conditioning for the slide switches and enable switch.
// Every line (N data switches plus the enable) gets its own two-flop
// synchroniser and its own stability counter. A new level is accepted only
// after it has been seen for DEB_CYCLES consecutive synchronised cycles.
// chg pulses for one cycle whenever any debounced output takes a new value.
module sw_debounce #(
   parameter int N          = 8,
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw_raw,
   input  logic         en_raw,
   output logic [N-1:0] x,
   output logic         en,
   output logic         chg
);

   // The enable is handled as the top channel, so all channels share one code path.
   localparam int CH = N + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [CH-1:0]    raw;
   logic [CH-1:0]    s1_q, s1_d;
   logic [CH-1:0]    s2_q, s2_d;
   logic [CH-1:0]    out_q, out_d;
   logic             chg_q, chg_d;
   logic [CNT_W-1:0] cnt_q [CH];
   logic [CNT_W-1:0] cnt_d [CH];

   assign raw = {en_raw, sw_raw};

   // Next-state logic: shift the synchronisers and run each channel's stability counter.
   always_comb begin
      s1_d  = raw;
      s2_d  = s1_q;
      out_d = out_q;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != out_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               out_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      chg_d = |(out_d ^ out_q);
   end

   // State registers; reset clears the synchronisers, counters and outputs at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         out_q <= '0;
         chg_q <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         out_q <= out_d;
         chg_q <= chg_d;
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign x   = out_q[N-1:0];
   assign en  = out_q[N];
   assign chg = chg_q;

endmodule
